// File: rtl/btb_update_queue.sv
// btb_update_queue: committed BTB update FIFO with tail coalescing and hold-gated drain
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE
`define BRANCH_TYPE 2
`endif
module btb_update_queue #(
  parameter int DEPTH = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic [`SIZE_PC-1:0]     pushPC_i,
  input  logic [`SIZE_PC-1:0]     pushTarget_i,
  input  logic [`BRANCH_TYPE-1:0] pushBrType_i,
  output logic                    ready_o,
  input  logic                    hold_i,
  output logic                    updateEn_o,
  output logic [`SIZE_PC-1:0]     updatePC_o,
  output logic [`SIZE_PC-1:0]     updateTargetAddr_o,
  output logic [`BRANCH_TYPE-1:0] updateBrType_o,
  output logic [DEPTH_LOG:0]      occupancy_o,
  output logic [15:0]             coalesceCnt_o
);
  localparam logic [DEPTH_LOG:0]   FULL    = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   CNT_ONE = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);
  logic [`SIZE_PC-1:0]     pc_mem  [DEPTH];
  logic [`SIZE_PC-1:0]     tgt_mem [DEPTH];
  logic [`BRANCH_TYPE-1:0] typ_mem [DEPTH];
  logic [DEPTH_LOG-1:0]    head, tail, last;
  logic [DEPTH_LOG:0]      count, count_next;
  logic [15:0]             coal_cnt;
  logic                    pop, accept, coalesce, alloc;
  assign ready_o            = count != FULL;
  assign updateEn_o         = pop;
  assign updatePC_o         = (count != '0) ? pc_mem[head] : '0;
  assign updateTargetAddr_o = (count != '0) ? tgt_mem[head] : '0;
  assign updateBrType_o     = (count != '0) ? typ_mem[head] : '0;
  assign occupancy_o        = count;
  assign coalesceCnt_o      = coal_cnt;
  // Handshake: a push merges into the newest entry unless that entry is leaving this cycle
  always_comb begin
    last       = tail - PTR_ONE;
    pop        = (count != '0) && !hold_i;
    accept     = push_i && ready_o;
    coalesce   = accept && (count != '0) && !(count == CNT_ONE && pop) && (pc_mem[last] == pushPC_i);
    alloc      = accept && !coalesce;
    count_next = (alloc && !pop) ? count + CNT_ONE : (!alloc && pop) ? count - CNT_ONE : count;
  end
  // Entry storage, pointers, occupancy and saturating coalesce counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        tgt_mem[i] <= '0;
        typ_mem[i] <= '0;
      end
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      coal_cnt <= '0;
    end else begin
      if (alloc) begin
        pc_mem[tail]  <= pushPC_i;
        tgt_mem[tail] <= pushTarget_i;
        typ_mem[tail] <= pushBrType_i;
        tail          <= tail + PTR_ONE;
      end
      if (coalesce) begin
        tgt_mem[last] <= pushTarget_i;
        typ_mem[last] <= pushBrType_i;
      end
      if (pop) head <= head + PTR_ONE;
      if (coalesce && coal_cnt != 16'hFFFF) coal_cnt <= coal_cnt + 16'd1;
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue: scoreboard bench for the BTB update queue
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE
`define BRANCH_TYPE 2
`endif
module tb_btb_update_queue;
  typedef struct {
    logic [`SIZE_PC-1:0]     pc;
    logic [`SIZE_PC-1:0]     tgt;
    logic [`BRANCH_TYPE-1:0] typ;
  } wr_t;
  logic                    clk = 0;
  logic                    reset = 1;
  logic                    push_i = 0;
  logic [`SIZE_PC-1:0]     pushPC_i = '0;
  logic [`SIZE_PC-1:0]     pushTarget_i = '0;
  logic [`BRANCH_TYPE-1:0] pushBrType_i = '0;
  logic                    ready_o;
  logic                    hold_i = 0;
  logic                    updateEn_o;
  logic [`SIZE_PC-1:0]     updatePC_o;
  logic [`SIZE_PC-1:0]     updateTargetAddr_o;
  logic [`BRANCH_TYPE-1:0] updateBrType_o;
  logic [3:0]              occupancy_o;
  logic [15:0]             coalesceCnt_o;
  wr_t sb[$];
  int  total = 0;
  int  bad = 0;
  btb_update_queue #(.DEPTH(8), .DEPTH_LOG(3)) dut (
    .clk(clk), .reset(reset), .push_i(push_i), .pushPC_i(pushPC_i),
    .pushTarget_i(pushTarget_i), .pushBrType_i(pushBrType_i), .ready_o(ready_o),
    .hold_i(hold_i), .updateEn_o(updateEn_o), .updatePC_o(updatePC_o),
    .updateTargetAddr_o(updateTargetAddr_o), .updateBrType_o(updateBrType_o),
    .occupancy_o(occupancy_o), .coalesceCnt_o(coalesceCnt_o)
  );
  always #5 clk = ~clk;
  // Monitor: every presented write must match the oldest expected write
  always @(negedge clk) begin
    if (updateEn_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got pc=%h tgt=%h typ=%0d, none expected", updatePC_o, updateTargetAddr_o, updateBrType_o);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (updatePC_o !== e.pc || updateTargetAddr_o !== e.tgt || updateBrType_o !== e.typ) begin
          bad++;
          $display("FAIL write_data got pc=%h tgt=%h typ=%0d, expected pc=%h tgt=%h typ=%0d",
                   updatePC_o, updateTargetAddr_o, updateBrType_o, e.pc, e.tgt, e.typ);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_push(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ, input logic hold);
    push_i = 1;
    pushPC_i = pc;
    pushTarget_i = tgt;
    pushBrType_i = typ;
    hold_i = hold;
    tick();
    push_i = 0;
  endtask
  task automatic expect_wr(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ);
    wr_t e;
    e.pc = pc;
    e.tgt = tgt;
    e.typ = typ;
    sb.push_back(e);
  endtask
  task automatic merge_last(input logic [31:0] tgt, input logic [1:0] typ);
    sb[sb.size()-1].tgt = tgt;
    sb[sb.size()-1].typ = typ;
  endtask
  initial begin
    #2;
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_en", 32'(updateEn_o), 0);
    chk("rst_occ", 32'(occupancy_o), 0);
    chk("rst_pc", updatePC_o, 0);
    chk("rst_coal", 32'(coalesceCnt_o), 0);
    tick();
    reset = 0;
    tick();
    push_i = 1;
    pushPC_i = 32'h100;
    pushTarget_i = 32'h200;
    pushBrType_i = 2'd1;
    #1;
    chk("no_bypass_en", 32'(updateEn_o), 0);
    chk("no_bypass_pc", updatePC_o, 0);
    expect_wr(32'h100, 32'h200, 2'd1);
    tick();
    push_i = 0;
    chk("single_occ", 32'(occupancy_o), 1);
    chk("single_en", 32'(updateEn_o), 1);
    tick();
    chk("single_done_en", 32'(updateEn_o), 0);
    chk("single_done_occ", 32'(occupancy_o), 0);
    for (int i = 0; i < 8; i++) begin
      do_push(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 2'(i), 1'b1);
      expect_wr(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 2'(i));
    end
    chk("full_occ", 32'(occupancy_o), 8);
    chk("full_ready", 32'(ready_o), 0);
    do_push(32'h5000, 32'h5555, 2'd3, 1'b1);
    chk("full_ignored_occ", 32'(occupancy_o), 8);
    chk("full_ignored_coal", 32'(coalesceCnt_o), 0);
    hold_i = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_en", 32'(updateEn_o), 1);
      tick();
    end
    chk("drain_occ", 32'(occupancy_o), 0);
    chk("drain_idle_en", 32'(updateEn_o), 0);
    do_push(32'h100, 32'h200, 2'd2, 1'b1);
    expect_wr(32'h100, 32'h200, 2'd2);
    do_push(32'h100, 32'h300, 2'd3, 1'b1);
    merge_last(32'h300, 2'd3);
    chk("coal_occ", 32'(occupancy_o), 1);
    chk("coal_cnt", 32'(coalesceCnt_o), 1);
    hold_i = 0;
    tick();
    chk("coal_drain_occ", 32'(occupancy_o), 0);
    do_push(32'h100, 32'h400, 2'd1, 1'b1);
    expect_wr(32'h100, 32'h400, 2'd1);
    do_push(32'h100, 32'h500, 2'd2, 1'b0);
    expect_wr(32'h100, 32'h500, 2'd2);
    chk("nocoal_pop_occ", 32'(occupancy_o), 1);
    chk("nocoal_pop_cnt", 32'(coalesceCnt_o), 1);
    tick();
    chk("nocoal_drain_occ", 32'(occupancy_o), 0);
    do_push(32'h600, 32'h1, 2'd0, 1'b1);
    expect_wr(32'h600, 32'h1, 2'd0);
    do_push(32'h700, 32'h2, 2'd0, 1'b1);
    expect_wr(32'h700, 32'h2, 2'd0);
    do_push(32'h700, 32'h3, 2'd1, 1'b0);
    merge_last(32'h3, 2'd1);
    chk("coal_pop_occ", 32'(occupancy_o), 1);
    chk("coal_pop_cnt", 32'(coalesceCnt_o), 2);
    tick();
    chk("coal_pop_drain", 32'(occupancy_o), 0);
    for (int i = 0; i < 8; i++) begin
      do_push(32'h3000 + 32'(i * 4), 32'h3100 + 32'(i), 2'(i + 1), 1'b1);
      expect_wr(32'h3000 + 32'(i * 4), 32'h3100 + 32'(i), 2'(i + 1));
    end
    do_push(32'h4000, 32'h4100, 2'd0, 1'b0);
    chk("full_pop_occ", 32'(occupancy_o), 7);
    chk("full_pop_ready", 32'(ready_o), 1);
    do_push(32'h4004, 32'h4104, 2'd1, 1'b0);
    expect_wr(32'h4004, 32'h4104, 2'd1);
    chk("push_pop_occ", 32'(occupancy_o), 7);
    repeat (7) tick();
    chk("full_drain_occ", 32'(occupancy_o), 0);
    for (int i = 0; i < 5; i++) do_push(32'h8000 + 32'(i * 4), 32'h9000, 2'd1, 1'b1);
    chk("pre_reset_occ", 32'(occupancy_o), 5);
    hold_i = 0;
    reset = 1;
    #1;
    chk("async_rst_occ", 32'(occupancy_o), 0);
    chk("async_rst_en", 32'(updateEn_o), 0);
    chk("async_rst_ready", 32'(ready_o), 1);
    chk("async_rst_coal", 32'(coalesceCnt_o), 0);
    tick();
    reset = 0;
    repeat (3) tick();
    chk("post_rst_occ", 32'(occupancy_o), 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btb_update_queue.md
BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of queue entries, a power of two and at least 2.
REQ-002 The block SHALL have parameter DEPTH_LOG, default 3: log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port push_i, input, 1 bit: the ctrl queue offers one committed control-instruction update this cycle.
REQ-006 The block SHALL have port pushPC_i, input, `SIZE_PC bits: PC of the offered control instruction.
REQ-007 The block SHALL have port pushTarget_i, input, `SIZE_PC bits: resolved target address.
REQ-008 The block SHALL have port pushBrType_i, input, `BRANCH_TYPE bits: control type.
REQ-009 The block SHALL have port ready_o, output, 1 bit: the queue can accept an offer this cycle.
REQ-010 The block SHALL have port hold_i, input, 1 bit: fetch requests no BTB write this cycle.
REQ-011 The block SHALL have port updateEn_o, output, 1 bit: BTB write enable.
REQ-012 The block SHALL have port updatePC_o, output, `SIZE_PC bits: BTB write PC.
REQ-013 The block SHALL have port updateTargetAddr_o, output, `SIZE_PC bits: BTB write target.
REQ-014 The block SHALL have port updateBrType_o, output, `BRANCH_TYPE bits: BTB write control type.
REQ-015 The block SHALL have port occupancy_o, output, DEPTH_LOG+1 bits: number of valid entries.
REQ-016 The block SHALL have port coalesceCnt_o, output, 16 bits: saturating count of coalesced pushes.

Function
REQ-017 The block SHALL be a circular FIFO with head pointer, tail pointer and count, each DEPTH_LOG bits (count DEPTH_LOG+1), with pointers wrapping modulo DEPTH.
REQ-018 ready_o SHALL equal (count != DEPTH) and SHALL NOT depend on a same-cycle pop.
REQ-019 A push SHALL be accepted only when push_i and ready_o are both high; push_i while full SHALL be ignored, with no state change and no counter change.
REQ-020 Pop: updateEn_o SHALL equal (count != 0) && !hold_i; the head entry SHALL be dequeued in the same cycle updateEn_o is high.
REQ-021 updatePC_o, updateTargetAddr_o and updateBrType_o SHALL show the head entry when count != 0 and SHALL be all zeros when count == 0.
REQ-022 There SHALL be no bypass: an entry accepted at edge N SHALL be presentable on the outputs no earlier than the cycle following edge N.
REQ-023 Coalesce: an accepted push whose pushPC_i equals the most-recent (tail-1) entry's PC SHALL overwrite that entry's target and type, SHALL NOT allocate an entry, and SHALL increment coalesceCnt_o.
REQ-024 Coalescing SHALL be suppressed when count == 0, or when count == 1 and that entry is popped in the same cycle; in both cases the push SHALL allocate a new entry.
REQ-025 A simultaneous accepted non-coalesced push and pop SHALL leave count unchanged.
REQ-026 A coalesced push with a simultaneous pop SHALL decrement count by 1.
REQ-027 coalesceCnt_o SHALL saturate at 16'hFFFF.
REQ-028 occupancy_o SHALL equal count at all times.
REQ-029 Entries SHALL be retained regardless of any BTB flush, because they are committed state.
REQ-030 Entries SHALL be written into the BTB in push order; a coalesced entry SHALL keep its original position in that order.

Reset
REQ-031 While reset is high: head = tail = count = 0, all entry storage zero, coalesceCnt_o = 0.
REQ-032 While reset is high the outputs SHALL be: ready_o = 1, updateEn_o = 0, all update data outputs 0, occupancy_o = 0.
REQ-033 Reset asserted mid-operation SHALL discard all pending entries immediately, with no BTB write in the reset cycle.

Verification
REQ-034 Scenario: push PC=0x100, T=0x200, type=1 with hold_i=0 -> next cycle updateEn_o=1 with 0x100/0x200/1; following cycle updateEn_o=0 and occupancy_o=0.
REQ-035 Scenario: hold_i=1; 8 distinct pushes -> occupancy_o=8 and ready_o=0; a 9th push is ignored; release hold_i -> 8 writes on consecutive cycles in push order.
REQ-036 Scenario: hold_i=1; push 0x100/T=0x200 then 0x100/T=0x300 -> occupancy_o=1 and coalesceCnt_o=1; after release, a single write of 0x100/0x300.
REQ-037 Scenario: count=1 holding 0x100 with hold_i=0 and same-PC push in that cycle -> entry popped, new entry allocated, occupancy_o=1, coalesceCnt_o unchanged.
REQ-038 Scenario: full queue, hold_i=0, push_i=1 -> push rejected, one pop, occupancy_o=7; next cycle push accepted with simultaneous pop, occupancy_o stays 7.
REQ-039 Scenario: reset asserted with occupancy 5 -> occupancy_o=0, updateEn_o=0 and ready_o=1 asynchronously, with no further writes.
